// File: rtl/exec_stage.sv
// SimpleRISC execute stage: ALU, E/GT flag register and branch resolution.
// Define EXEC_ITER_DIV_EN for the 34-cycle iterative DIV/MOD; otherwise DIV/MOD are single-cycle.
module exec_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        alu_op,
  input  logic              use_imm,
  input  logic [DATA_W-1:0] rs1_val,
  input  logic [DATA_W-1:0] rs2_val,
  input  logic [DATA_W-1:0] imm,
  input  logic              is_cmp,
  input  logic              is_beq,
  input  logic              is_bgt,
  input  logic              is_b,
  input  logic              is_call,
  input  logic              is_ret,
  input  logic [PC_W-1:0]   branch_target,
  input  logic [PC_W-1:0]   ra_val,
  output logic              out_valid,
  output logic [DATA_W-1:0] result,
  output logic              branch_taken,
  output logic [PC_W-1:0]   branch_pc,
  output logic              flag_e,
  output logic              flag_gt
);

  // ALU_* codes shared with decode.vh
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MUL  = 4'd2;
  localparam logic [3:0] ALU_DIV  = 4'd3;
  localparam logic [3:0] ALU_MOD  = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_NOT  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_PASS = 4'd11;
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] op_a, op_b, alu_res;
  logic              is_br, br_taken_c;
  logic [PC_W-1:0]   br_pc_c;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              branch_taken_q, branch_taken_d;
  logic [PC_W-1:0]   branch_pc_q, branch_pc_d;
  logic              flag_e_q, flag_e_d, flag_gt_q, flag_gt_d;

  assign op_a       = rs1_val;
  assign op_b       = use_imm ? imm : rs2_val;
  assign is_br      = is_beq | is_bgt | is_b | is_call | is_ret;
  assign br_taken_c = (is_beq & flag_e_q) | (is_bgt & flag_gt_q) | is_b | is_call | is_ret;
  assign br_pc_c    = is_ret ? ra_val : branch_target;

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign branch_taken = branch_taken_q;
  assign branch_pc    = branch_pc_q;
  assign flag_e       = flag_e_q;
  assign flag_gt      = flag_gt_q;

`ifdef EXEC_ITER_DIV_EN
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  typedef enum logic [1:0] {IDLE, DIV_BUSY, DIV_FIX} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d;
  logic              mod_q, mod_d;
  logic              is_divmod;
  logic [DATA_W:0]   rem_sh, diff;

  assign in_ready  = in_ready_q;
  assign is_divmod = ((alu_op == ALU_DIV) || (alu_op == ALU_MOD)) && !is_cmp && !is_br;
`else
  logic              div_zero, div_ovf;
  logic [DATA_W-1:0] safe_b, comb_q, comb_r;

  assign in_ready = 1'b1;

  // Substitute a harmless divisor for the special cases, then override their results
  always_comb begin
    div_zero = (op_b == '0);
    div_ovf  = (op_a == MIN_NEG) && (op_b == '1);
    safe_b   = (div_zero || div_ovf) ? DATA_W'(1) : op_b;
    comb_q   = DATA_W'($signed(op_a) / $signed(safe_b));
    comb_r   = DATA_W'($signed(op_a) % $signed(safe_b));
    if (div_zero) begin
      comb_q = '1;
      comb_r = op_a;
    end else if (div_ovf) begin
      comb_q = MIN_NEG;
      comb_r = '0;
    end
  end
`endif

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_MUL:  alu_res = DATA_W'(op_a * op_b);
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_NOT:  alu_res = ~op_b;
      ALU_SLL:  alu_res = op_a << op_b[4:0];
      ALU_SRL:  alu_res = op_a >> op_b[4:0];
      ALU_SRA:  alu_res = DATA_W'($signed(op_a) >>> op_b[4:0]);
      ALU_PASS: alu_res = op_b;
`ifndef EXEC_ITER_DIV_EN
      ALU_DIV:  alu_res = comb_q;
      ALU_MOD:  alu_res = comb_r;
`endif
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    out_valid_d    = 1'b0;
    result_d       = result_q;
    branch_taken_d = branch_taken_q;
    branch_pc_d    = branch_pc_q;
    flag_e_d       = flag_e_q;
    flag_gt_d      = flag_gt_q;
`ifdef EXEC_ITER_DIV_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mod_d   = mod_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvs_d   = dvs_q;
    rem_sh  = '0;
    diff    = '0;
`endif
    if (in_valid && in_ready) begin
`ifdef EXEC_ITER_DIV_EN
      if (is_divmod) begin
        state_d = DIV_BUSY;
        cnt_d   = '0;
        a_d     = op_a;
        b_d     = op_b;
        mod_d   = (alu_op == ALU_MOD);
      end else
`endif
      begin
        out_valid_d    = 1'b1;
        result_d       = (is_cmp || is_br) ? '0 : alu_res;
        branch_taken_d = br_taken_c;
        branch_pc_d    = br_taken_c ? br_pc_c : '0;
        if (is_cmp) begin
          flag_e_d  = (op_a == op_b);
          flag_gt_d = ($signed(op_a) > $signed(op_b));
        end
      end
    end
`ifdef EXEC_ITER_DIV_EN
    case (state_q)
      // Count 0 loads magnitudes; counts 1..DATA_W are restoring-divide steps
      DIV_BUSY: begin
        if (cnt_q == '0) begin
          rem_d  = '0;
          quot_d = a_q[DATA_W-1] ? -a_q : a_q;
          dvs_d  = b_q[DATA_W-1] ? -b_q : b_q;
        end else begin
          rem_sh = {rem_q, quot_q[DATA_W-1]};
          diff   = rem_sh - {1'b0, dvs_q};
          if (!diff[DATA_W]) begin
            rem_d  = diff[DATA_W-1:0];
            quot_d = {quot_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d  = rem_sh[DATA_W-1:0];
            quot_d = {quot_q[DATA_W-2:0], 1'b0};
          end
        end
        if (cnt_q == CNT_W'(DATA_W)) begin
          cnt_d   = '0;
          state_d = DIV_FIX;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // MIN_NEG / -1 falls out of the magnitude divide as MIN_NEG with remainder 0
      DIV_FIX: begin
        out_valid_d    = 1'b1;
        branch_taken_d = 1'b0;
        branch_pc_d    = '0;
        state_d        = IDLE;
        if (b_q == '0)  result_d = mod_q ? a_q : '1;
        else if (mod_q) result_d = a_q[DATA_W-1] ? -rem_q : rem_q;
        else            result_d = (a_q[DATA_W-1] ^ b_q[DATA_W-1]) ? -quot_q : quot_q;
      end
      default: ;
    endcase
    in_ready_d = (state_d == IDLE);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      result_q       <= '0;
      branch_taken_q <= 1'b0;
      branch_pc_q    <= '0;
      flag_e_q       <= 1'b0;
      flag_gt_q      <= 1'b0;
`ifdef EXEC_ITER_DIV_EN
      state_q    <= IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b1;
      a_q        <= '0;
      b_q        <= '0;
      mod_q      <= 1'b0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
`endif
    end else begin
      out_valid_q    <= out_valid_d;
      result_q       <= result_d;
      branch_taken_q <= branch_taken_d;
      branch_pc_q    <= branch_pc_d;
      flag_e_q       <= flag_e_d;
      flag_gt_q      <= flag_gt_d;
`ifdef EXEC_ITER_DIV_EN
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      a_q        <= a_d;
      b_q        <= b_d;
      mod_q      <= mod_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvs_q      <= dvs_d;
`endif
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed test-plan cases plus randomized ops
// against an arithmetic reference model of the ALU, flags and branch rules.
module tb_exec_stage;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MUL  = 4'd2;
  localparam logic [3:0] ALU_DIV  = 4'd3;
  localparam logic [3:0] ALU_MOD  = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_NOT  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_PASS = 4'd11;

`ifdef EXEC_ITER_DIV_EN
  localparam int DIV_LAT = 34;
`else
  localparam int DIV_LAT = 0;
`endif

  // kind encoding for send(): 0 none, 1 cmp, 2 beq, 3 bgt, 4 b, 5 call, 6 ret
  logic        clk, rst, in_valid, in_ready, use_imm;
  logic [3:0]  alu_op;
  logic [31:0] rs1_val, rs2_val, imm, branch_target, ra_val;
  logic        is_cmp, is_beq, is_bgt, is_b, is_call, is_ret;
  logic        out_valid, branch_taken, flag_e, flag_gt;
  logic [31:0] result, branch_pc;

  int errors = 0;
  int checks = 0;
  logic m_fe = 1'b0;
  logic m_fgt = 1'b0;

  exec_stage #(.DATA_W(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .use_imm(use_imm), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .is_cmp(is_cmp), .is_beq(is_beq), .is_bgt(is_bgt), .is_b(is_b), .is_call(is_call),
    .is_ret(is_ret), .branch_target(branch_target), .ra_val(ra_val),
    .out_valid(out_valid), .result(result), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .flag_e(flag_e), .flag_gt(flag_gt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    logic [63:0] ua = {32'd0, a};
    logic [63:0] ub = {32'd0, b};
    logic [4:0] sh = b[4:0];
    longint p = longint'(1) << sh;
    case (op)
      ALU_ADD:  return 32'(ua + ub);
      ALU_SUB:  return 32'(ua - ub);
      ALU_MUL:  return 32'(ua * ub);
      ALU_DIV:  return (b == 0) ? 32'hFFFFFFFF : 32'(sa / sb);
      ALU_MOD:  return (b == 0) ? a : 32'(sa % sb);
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_NOT:  return ~b;
      ALU_SLL:  return 32'(ua * 64'(p));
      ALU_SRL:  return 32'(ua / 64'(p));
      ALU_SRA:  return (sa >= 0) ? 32'(sa / p) : 32'(-((-sa + p - 1) / p));
      ALU_PASS: return b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input int kind);
    return (kind == 2 && m_fe) || (kind == 3 && m_fgt) || (kind >= 4);
  endfunction

  task automatic model_cmp(input logic [31:0] a, input logic [31:0] b);
    m_fe  = (a == b);
    m_fgt = ($signed(a) > $signed(b));
  endtask

  // Presents one instruction, holds it until accepted, returns #1 after the accepting edge
  task automatic send(input logic [3:0] op, input logic ui, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] im, input int kind, input logic [31:0] tgt, input logic [31:0] ra);
    int n = 0;
    alu_op = op; use_imm = ui; rs1_val = a; rs2_val = b; imm = im;
    is_cmp = (kind == 1); is_beq = (kind == 2); is_bgt = (kind == 3);
    is_b = (kind == 4); is_call = (kind == 5); is_ret = (kind == 6);
    branch_target = tgt; ra_val = ra; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    is_cmp = 0; is_beq = 0; is_bgt = 0; is_b = 0; is_call = 0; is_ret = 0;
  endtask

  // lat = edges after acceptance until out_valid; busy = samples with in_ready low meanwhile
  task automatic wait_out(output int lat, output int busy);
    lat = 0;
    busy = in_ready ? 0 : 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
      if (!in_ready) busy++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks += 7;
    if (in_ready !== 1'b1)     begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    if (out_valid !== 1'b0)    begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (result !== 32'd0)      begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    if (branch_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b want 0", branch_taken); end
    if (branch_pc !== 32'd0)   begin errors++; $display("FAIL reset_pc: got %h want 0", branch_pc); end
    if (flag_e !== 1'b0)       begin errors++; $display("FAIL reset_flag_e: got %b want 0", flag_e); end
    if (flag_gt !== 1'b0)      begin errors++; $display("FAIL reset_flag_gt: got %b want 0", flag_gt); end
    rst = 1'b0;
    m_fe = 0; m_fgt = 0;
  endtask

  task automatic test_add_imm();
    send(ALU_ADD, 1'b1, 32'd7, 32'd100, 32'hFFFFFFFD, 0, 32'd0, 32'd0);
    checks += 4;
    if (out_valid !== 1'b1)  begin errors++; $display("FAIL add_valid: got %b want 1", out_valid); end
    if (result !== 32'd4)    begin errors++; $display("FAIL add_result: got %h want 4", result); end
    if (flag_e !== 1'b0)     begin errors++; $display("FAIL add_flag_e: got %b want 0", flag_e); end
    if (flag_gt !== 1'b0)    begin errors++; $display("FAIL add_flag_gt: got %b want 0", flag_gt); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0)  begin errors++; $display("FAIL add_pulse: got %b want 0", out_valid); end
  endtask

  task automatic test_cmp_branch();
    logic [31:0] ca [3] = '{32'd5, 32'd3, 32'd6};
    logic [31:0] cb [3] = '{32'd5, 32'd5, 32'hFFFFFFFF};
    logic        we [3] = '{1'b1, 1'b0, 1'b0};
    logic        wg [3] = '{1'b0, 1'b0, 1'b1};
    int          bk [3] = '{2, 2, 3};
    logic        wt [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      send(ALU_SUB, 1'b0, ca[i], cb[i], 32'd0, 1, 32'd0, 32'd0);
      model_cmp(ca[i], cb[i]);
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL cmp%0d_valid: got %b want 1", i, out_valid); end
      if (result !== 32'd0)   begin errors++; $display("FAIL cmp%0d_result: got %h want 0", i, result); end
      if (flag_e !== we[i])   begin errors++; $display("FAIL cmp%0d_flag_e: got %b want %b", i, flag_e, we[i]); end
      if (flag_gt !== wg[i])  begin errors++; $display("FAIL cmp%0d_flag_gt: got %b want %b", i, flag_gt, wg[i]); end
      send(ALU_ADD, 1'b0, 32'd1, 32'd2, 32'd0, bk[i], 32'h40, 32'd0);
      checks += 3;
      if (out_valid !== 1'b1)     begin errors++; $display("FAIL br%0d_valid: got %b want 1", i, out_valid); end
      if (branch_taken !== wt[i]) begin errors++; $display("FAIL br%0d_taken: got %b want %b", i, branch_taken, wt[i]); end
      if (wt[i] && branch_pc !== 32'h40) begin
        errors++; $display("FAIL br%0d_pc: got %h want 40", i, branch_pc);
      end
    end
  endtask

  task automatic test_div();
    logic [3:0]  op [6] = '{ALU_DIV, ALU_MOD, ALU_DIV, ALU_MOD, ALU_DIV, ALU_MOD};
    logic [31:0] da [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd9, 32'd9, 32'h80000000, 32'h80000000};
    logic [31:0] db [6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] dr [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9, 32'h80000000, 32'd0};
    int lat, busy;
    for (int i = 0; i < 6; i++) begin
      send(op[i], 1'b0, da[i], db[i], 32'd0, 0, 32'd0, 32'd0);
      wait_out(lat, busy);
      checks += 6;
      if (lat != DIV_LAT)     begin errors++; $display("FAIL div%0d_latency: got %0d want %0d", i, lat, DIV_LAT); end
      if (busy != DIV_LAT)    begin errors++; $display("FAIL div%0d_busy: got %0d want %0d", i, busy, DIV_LAT); end
      if (out_valid !== 1'b1) begin errors++; $display("FAIL div%0d_valid: got %b want 1", i, out_valid); end
      if (result !== dr[i])   begin errors++; $display("FAIL div%0d_result: got %h want %h", i, result, dr[i]); end
      if (in_ready !== 1'b1)  begin errors++; $display("FAIL div%0d_ready_after: got %b want 1", i, in_ready); end
      if (flag_e !== m_fe || flag_gt !== m_fgt) begin
        errors++; $display("FAIL div%0d_flags: got %b%b want %b%b", i, flag_e, flag_gt, m_fe, m_fgt);
      end
    end
  endtask

  task automatic test_shift_ret();
    send(ALU_SRA, 1'b0, 32'h80000000, 32'h24, 32'd0, 0, 32'd0, 32'd0);
    checks++;
    if (result !== 32'hF8000000) begin errors++; $display("FAIL sra_result: got %h want f8000000", result); end
    send(ALU_ADD, 1'b0, 32'd3, 32'd4, 32'd0, 6, 32'h77, 32'h1234);
    checks += 4;
    if (out_valid !== 1'b1)       begin errors++; $display("FAIL ret_valid: got %b want 1", out_valid); end
    if (branch_taken !== 1'b1)    begin errors++; $display("FAIL ret_taken: got %b want 1", branch_taken); end
    if (branch_pc !== 32'h1234)   begin errors++; $display("FAIL ret_pc: got %h want 1234", branch_pc); end
    if (result !== 32'd0)         begin errors++; $display("FAIL ret_result: got %h want 0", result); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom();
      b = $urandom();
      send(ALU_ADD, 1'b0, a, b, 32'd0, 0, 32'd0, 32'd0);
      checks += 2;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b%0d_valid: got %b want 1", i, out_valid); end
      if (result !== ref_alu(ALU_ADD, a, b)) begin
        errors++; $display("FAIL b2b%0d_result: got %h want %h", i, result, ref_alu(ALU_ADD, a, b));
      end
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse_end: got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic        ui;
    logic [31:0] a, b, im, tgt, ra, bv, exp_res, exp_pc;
    logic        exp_tk;
    int          kind, lat, busy, exp_lat;
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 1) ? 0 : int'($urandom_range(1, 6));
      op = 4'($urandom_range(0, 11));
      while (kind != 0 && (op == ALU_DIV || op == ALU_MOD)) op = 4'($urandom_range(0, 11));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom();
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom();
      if ($urandom_range(0, 4) == 0) b = a;
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      ui = 1'($urandom_range(0, 1));
      im = ($urandom_range(0, 1) == 0) ? 32'($signed($urandom_range(0, 15)) - 8) : b;
      tgt = $urandom();
      ra  = $urandom();
      bv  = ui ? im : b;
      exp_res = (kind != 0) ? 32'd0 : ref_alu(op, a, bv);
      exp_tk  = ref_taken(kind);
      exp_pc  = (kind == 6) ? ra : tgt;
      exp_lat = (kind == 0 && (op == ALU_DIV || op == ALU_MOD)) ? DIV_LAT : 0;
      send(op, ui, a, b, im, kind, tgt, ra);
      wait_out(lat, busy);
      if (kind == 1) model_cmp(a, bv);
      checks += 4;
      if (lat != exp_lat)          begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, exp_lat); end
      if (result !== exp_res)      begin errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h want %h", i, op, a, bv, result, exp_res); end
      if (branch_taken !== exp_tk) begin errors++; $display("FAIL rnd%0d_taken kind=%0d: got %b want %b", i, kind, branch_taken, exp_tk); end
      if (flag_e !== m_fe || flag_gt !== m_fgt) begin
        errors++; $display("FAIL rnd%0d_flags: got %b%b want %b%b", i, flag_e, flag_gt, m_fe, m_fgt);
      end
      if (exp_tk) begin
        checks++;
        if (branch_pc !== exp_pc) begin errors++; $display("FAIL rnd%0d_pc: got %h want %h", i, branch_pc, exp_pc); end
      end
    end
  endtask

  task automatic test_reset_mid_div();
    int pulses = 0;
    send(ALU_SUB, 1'b0, 32'd5, 32'd5, 32'd0, 1, 32'd0, 32'd0);
    send(ALU_DIV, 1'b0, 32'd1000, 32'd7, 32'd0, 0, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (out_valid) pulses++;
      @(posedge clk); #1;
    end
    checks++;
    if (pulses != ((DIV_LAT == 0) ? 1 : 0)) begin
      errors++; $display("FAIL rstdiv_early_pulses: got %0d want %0d", pulses, (DIV_LAT == 0) ? 1 : 0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_fe = 0; m_fgt = 0;
    checks += 4;
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL rstdiv_ready: got %b want 1", in_ready); end
    if (flag_e !== 1'b0)    begin errors++; $display("FAIL rstdiv_flag_e: got %b want 0", flag_e); end
    if (flag_gt !== 1'b0)   begin errors++; $display("FAIL rstdiv_flag_gt: got %b want 0", flag_gt); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstdiv_valid: got %b want 0", out_valid); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL rstdiv_late_pulses: got %0d want 0", pulses); end
    send(ALU_ADD, 1'b0, 32'd1, 32'd1, 32'd0, 0, 32'd0, 32'd0);
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rstdiv_add_valid: got %b want 1", out_valid); end
    if (result !== 32'd2)   begin errors++; $display("FAIL rstdiv_add_result: got %h want 2", result); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_op = 4'd0; use_imm = 1'b0;
    rs1_val = 0; rs2_val = 0; imm = 0; branch_target = 0; ra_val = 0;
    is_cmp = 0; is_beq = 0; is_bgt = 0; is_b = 0; is_call = 0; is_ret = 0;
    test_reset();
    test_add_imm();
    test_cmp_branch();
    test_div();
    test_shift_ret();
    test_back_to_back();
    test_random();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
# exec_stage

Execute stage of the SimpleRISC core, directly downstream of the control unit. Accepts one decoded instruction per handshake (ALU opcode, operand values, branch/compare strobes), computes the 32-bit ALU result, maintains the architectural E/GT flags register, and resolves branches. DIV/MOD run on an iterative signed divider that stalls the stage; all other operations complete in one cycle.

## Interface
- `DATA_W`, 32, operand/result width; only 32 is supported.
- `PC_W`, 32, program-counter and branch-target width.
- `clk` in 1, sole clock; all state updates on the rising edge.
- `rst` in 1, synchronous, active-high.
- `in_valid` in 1, decoded instruction present.
- `in_ready` out 1, stage can accept; an instruction transfers when `in_valid && in_ready`.
- `alu_op` in 4, `ALU_*` code from `decode.vh`.
- `use_imm` in 1, selects `imm` instead of `rs2_val` as operand B.
- `rs1_val`, `rs2_val`, `imm` in DATA_W each, operand A, register operand B, sign-extended immediate.
- `is_cmp`, `is_beq`, `is_bgt`, `is_b`, `is_call`, `is_ret` in 1 each, strobes from the control unit; at most one is set.
- `branch_target` in PC_W, target for beq/bgt/b/call.
- `ra_val` in PC_W, return-address register value for ret.
- `out_valid` out 1, one-cycle pulse; downstream always accepts.
- `result` out DATA_W, ALU result; 0 for cmp and branches.
- `branch_taken` out 1, valid with `out_valid`.
- `branch_pc` out PC_W, redirect target, valid when `branch_taken`.
- `flag_e`, `flag_gt` out 1 each, architectural flags.

## Operation
- B = `use_imm ? imm : rs2_val`; A = `rs1_val`. Operands are latched at acceptance.
- Op semantics:
  - ADD/SUB/AND/OR: mod 2^32.
  - MUL: low 32 bits of the product.
  - SLL/SRL/SRA: shift A by B[4:0].
  - NOT: ~B. PASS: B.
- DIV/MOD: signed, truncating toward zero; the remainder takes the dividend's sign.
  - B=0: DIV→0xFFFFFFFF, MOD→A.
  - A=0x80000000, B=0xFFFFFFFF: DIV→0x80000000, MOD→0.
- CMP: flag_e←(A==B), flag_gt←($signed(A)>$signed(B)), written on the acceptance edge. All other ops leave the flags unchanged.
- Branch resolution uses the flag register value at the acceptance cycle, so a cmp accepted in cycle N is seen by a beq accepted in cycle N+1.
  - beq is taken if flag_e; bgt is taken if flag_gt; b and call are always taken with branch_pc=branch_target.
  - ret is always taken with branch_pc=ra_val.
- FSM states:
  - IDLE (in_ready=1): a non-DIV/MOD accept stays in IDLE; a DIV/MOD accept goes to DIV_BUSY.
  - DIV_BUSY (in_ready=0): runs a 32-iteration restoring divide on magnitudes, then goes to DIV_FIX.
  - DIV_FIX (in_ready=0): applies signs and the special cases, asserts out_valid, then returns to IDLE.
- Reset values: in_ready=1, out_valid=0, result=0, branch_taken=0, branch_pc=0, flag_e=0, flag_gt=0, FSM=IDLE, iteration counter=0.
- Reset mid-divide: the divide is abandoned. No out_valid is issued for it, and in_ready=1 on the first cycle after reset.

## Timing
- Single-cycle ops: accepted at edge N; result, branch_taken, branch_pc and out_valid are registered and visible after edge N (latency 1). Back-to-back throughput is 1 per cycle.
- DIV/MOD (iterative): accepted at edge N; out_valid after edge N+34 (1 setup + 32 iterations + 1 fix). in_ready is low from after edge N until after edge N+34.
  - An instruction presented during the result cycle is accepted at edge N+34 or later.
- out_valid is held exactly one cycle per accepted instruction, including cmp and not-taken branches.
- in_valid while in_ready=0 is ignored. Upstream must hold the instruction.

## Configuration
- `EXEC_ITER_DIV_EN` defined: DIV/MOD use the iterative FSM above with 34-cycle latency.
- `EXEC_ITER_DIV_EN` undefined: DIV/MOD are computed combinationally with `/` and `%` and the same special-case results. They have latency 1, in_ready is tied to 1, and DIV_BUSY/DIV_FIX are not built.

## Test plan
- Reset, then ADD A=7, B=imm 0xFFFFFFFD, use_imm=1 → one cycle later out_valid=1, result=4; flags remain 0.
- CMP A=5, B=5, then beq target 0x40 on the next cycle → flag_e=1, flag_gt=0; beq out_valid with branch_taken=1, branch_pc=0x40. Repeat with CMP A=3, B=5 → beq branch_taken=0.
- DIV A=−7, B=2 (iterative) → in_ready low for 34 cycles, result=0xFFFFFFFD; MOD with the same operands → 0xFFFFFFFF.
- DIV A=9, B=0 → 0xFFFFFFFF; MOD A=9, B=0 → 9; DIV 0x80000000 by 0xFFFFFFFF → 0x80000000.
- SRA A=0x80000000, B=0x24 → 0xF8000000 (shift 4). ret with ra_val=0x1234 → branch_taken=1, branch_pc=0x1234, result=0.
- Assert rst 10 cycles into a DIV → no out_valid; in_ready=1 and flags=0 the cycle after reset; a following ADD 1+1 → result 2.
